// File: rtl/axi4_mul_responder.sv
// AXI4 responder for the multiplier operand/result link: burst-written operands,
// shift-add multiply, burst read-back. `AXI4_MUL_RADIX4_EN selects 2 bits/clk.
module axi4_mul_responder #(
    parameter int SZ  = 32,
    parameter int DSZ = 8,
    parameter int ASZ = 2
) (
    input  logic           clk,
    input  logic           _rst,
    input  logic [ASZ-1:0] awaddr,
    input  logic           awvalid,
    output logic           awready,
    input  logic [DSZ-1:0] wdata,
    input  logic           wvalid,
    output logic           wready,
    input  logic           wlast,
    output logic           bresp,
    output logic           bvalid,
    input  logic           bready,
    input  logic [ASZ-1:0] araddr,
    input  logic           arvalid,
    output logic           arready,
    output logic [DSZ-1:0] rdata,
    output logic           rvalid,
    input  logic           rready,
    output logic           rlast,
    output logic           rresp
);
    localparam int NB = SZ / DSZ;
    localparam int PB = 2 * NB;
    localparam int CW = $clog2(PB + 1);
`ifdef AXI4_MUL_RADIX4_EN
    localparam int ITERS = SZ / 2;
`else
    localparam int ITERS = SZ;
`endif
    localparam int IW = $clog2(ITERS + 1);
    localparam logic [CW-1:0] NB_C = CW'(NB);

    typedef enum logic [2:0] {
        IDLE, WDATA, WRESP, RWAIT, RDATA
    } state_t;

    state_t          state, state_nx;
    logic            rdy_q;
    logic [ASZ-1:0]  addr_q;
    logic [CW-1:0]   cnt, cnt_inc, last_idx;
    logic            err;
    logic [SZ-1:0]   shadow, op_a, op_b;
    logic [SZ-1:0]   next_a, next_b, mplier;
    logic [2*SZ-1:0] product, mcand, src;
    logic [IW-1:0]   iter;
    logic            busy, done;
    logic [1:0]      stat_q;
    logic            aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic            commit, rd_last;
    logic            is_a, is_b, is_p;

    assign aw_hs   = (state == IDLE) && rdy_q && awvalid;
    assign ar_hs   = (state == IDLE) && rdy_q && arvalid && !awvalid;
    assign w_hs    = (state == WDATA) && wvalid;
    assign b_hs    = (state == WRESP) && bready;
    assign r_hs    = (state == RDATA) && rready;
    assign commit  = b_hs && !err;
    assign cnt_inc = (cnt < NB_C) ? cnt + CW'(1) : cnt;
    assign is_a    = addr_q == ASZ'(0);
    assign is_b    = addr_q == ASZ'(1);
    assign is_p    = addr_q == ASZ'(2);
    assign next_a  = (commit && is_a) ? shadow : op_a;
    assign next_b  = (commit && is_b) ? shadow : op_b;

    always_comb begin
        last_idx = '0;
        src      = {{(2*SZ-2){1'b0}}, stat_q};
        unique case (1'b1)
            is_a: begin
                last_idx = CW'(NB - 1);
                src      = {{SZ{1'b0}}, op_a};
            end
            is_b: begin
                last_idx = CW'(NB - 1);
                src      = {{SZ{1'b0}}, op_b};
            end
            is_p: begin
                last_idx = CW'(PB - 1);
                src      = product;
            end
            default: ;
        endcase
    end

    assign rd_last = cnt == last_idx;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (aw_hs)
                    state_nx = WDATA;
                else if (ar_hs)
                    state_nx = (araddr == ASZ'(2) && busy)
                             ? RWAIT : RDATA;
            end
            WDATA: if (w_hs && wlast) state_nx = WRESP;
            WRESP: if (b_hs) state_nx = IDLE;
            RWAIT: if (!busy) state_nx = RDATA;
            RDATA: if (r_hs && rd_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            rdy_q  <= 1'b0;
            addr_q <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            shadow <= '0;
            stat_q <= '0;
        end else begin
            rdy_q <= state_nx == IDLE;
            if (aw_hs) begin
                addr_q <= awaddr;
                cnt    <= '0;
                err    <= awaddr > ASZ'(1);
            end
            if (ar_hs) begin
                addr_q <= araddr;
                cnt    <= '0;
                stat_q <= {busy, done};
            end
            if (w_hs) begin
                if (cnt < NB_C)
                    shadow[int'(cnt)*DSZ +: DSZ] <= wdata;
                else
                    err <= 1'b1;
                cnt <= cnt_inc;
                // short bursts are only detectable once wlast arrives
                if (wlast && cnt_inc != NB_C)
                    err <= 1'b1;
            end
            if (r_hs)
                cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge _rst) begin
        if (_rst) begin
            op_a    <= '0;
            op_b    <= '0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            iter    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (commit) begin
            op_a    <= next_a;
            op_b    <= next_b;
            product <= '0;
            mcand   <= {{SZ{1'b0}}, next_a};
            mplier  <= next_b;
            iter    <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else if (busy) begin
`ifdef AXI4_MUL_RADIX4_EN
            product <= product
                     + (mplier[0] ? mcand : '0)
                     + (mplier[1] ? {mcand[2*SZ-2:0], 1'b0} : '0);
            mcand   <= {mcand[2*SZ-3:0], 2'b00};
            mplier  <= {2'b00, mplier[SZ-1:2]};
`else
            product <= product + (mplier[0] ? mcand : '0);
            mcand   <= {mcand[2*SZ-2:0], 1'b0};
            mplier  <= {1'b0, mplier[SZ-1:1]};
`endif
            iter <= iter + IW'(1);
            if (iter == IW'(ITERS - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    assign awready = rdy_q && (state == IDLE);
    // a pending write always wins the IDLE arbitration
    assign arready = rdy_q && (state == IDLE) && !awvalid;
    assign wready  = state == WDATA;
    assign bvalid  = state == WRESP;
    assign bresp   = bvalid && !err;
    assign rvalid  = state == RDATA;
    assign rresp   = rvalid;
    assign rlast   = rvalid && rd_last;
    assign rdata   = rvalid ? src[int'(cnt)*DSZ +: DSZ] : '0;

endmodule

// File: doc/axi4_mul_responder.md
Name: axi4_mul_responder

Overview:
- AXI4 responder (slave end) of the narrow operand/result link driven by the multiplier master wrapper.
- Accepts operand A and operand B as DSZ-bit write bursts and runs a sequential shift-add multiply.
- Returns the 2*SZ-bit product, operand readback and status as DSZ-bit read bursts.
- Single outstanding transaction; drop-in partner for the existing master on the same channel set.

Parameters:
SZ, 32, operand width in bits; must be a multiple of DSZ
DSZ, 8, data beat width in bits
ASZ, 2, address width; map: 0=A, 1=B, 2=product, 3=status

Ports:
clk  input  1  clock
_rst  input  1  asynchronous, active-high reset
awaddr  input  ASZ  write address
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  DSZ  write beat data, little-endian beat order
wvalid  input  1  write beat valid
wready  output  1  write beat ready
wlast  input  1  final write beat
bresp  output  1  write response; 1 => ok, 0 => error
bvalid  output  1  write response valid
bready  input  1  write response ready
araddr  input  ASZ  read address
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  DSZ  read beat data
rvalid  output  1  read beat valid
rready  input  1  read beat ready
rlast  output  1  final read beat
rresp  output  1  read response; 1 => ok

Behaviour:
- Reset: all outputs 0; A=B=product=0; done=0; busy=0; FSM=IDLE. Reset mid-transaction or mid-multiply aborts immediately, no response issued.
- FSM states: IDLE, WDATA, WRESP, RWAIT, RDATA.
- IDLE:
  - awready=arready=1, registered.
  - Handshake: valid&ready on the same edge.
  - If awvalid and arvalid are both high, the write wins; arready drops the same cycle the AW handshake happens.
  - AW handshake -> WDATA. Latch address; beat count=0; error flag = (addr>1).
  - AR handshake -> RWAIT if addr==2 and busy, else RDATA.
- WDATA:
  - wready=1.
  - Each accepted beat with count<SZ/DSZ is stored into shadow byte [count]; count increments.
  - Extra beats are accepted, discarded and set the error flag.
  - Beat with wlast -> WRESP. Error is also set if the final count differs from SZ/DSZ.
- WRESP:
  - bvalid=1 starting the cycle after the wlast beat; bresp=!error; holds until bready.
  - On bvalid&bready: shadow is committed to A or B only if bresp=1, and then the multiplier (re)starts. Next state IDLE.
- Multiplier:
  - On start: busy=1, done=0, product=0.
  - SZ iterations, one bit per clk (LSB-first shift-add on a 2*SZ accumulator, no overflow).
  - Last iteration: busy=0, done=1, product valid.
  - A commit while busy restarts the computation with the new operands.
- RWAIT: holds until busy=0, then -> RDATA. arready stays 0.
- RDATA:
  - rvalid=1, rresp=1.
  - Beat counts: addr0/1 = SZ/DSZ beats; addr2 = 2*SZ/DSZ beats; addr3 = 1 beat of {0..., busy, done}.
  - rdata = beat[count], LSB beat first; rlast=1 on the final beat only.
  - rdata, rlast and rvalid are stable while rready=0.
  - Beat advances on rvalid&rready; rlast accepted -> IDLE.
- Back-to-back: a new address handshake is possible the cycle after return to IDLE (1 idle cycle between transactions).

Optional Feature:
- Macro: AXI4_MUL_RADIX4_EN.
- Defined: the multiplier retires 2 bits per clk; latency is SZ/2 cycles; SZ must be even.
- Undefined: radix-2, SZ cycles as above.
- Results and bus behaviour are identical either way; only busy duration changes.

Test Plan:
- Write A=10234 (beats FA 27 00 00, wlast on 4th) and B=566 (36 02 00 00), then read addr2 -> beats BC 62 58 00 00 00 00 00, rlast on 8th, rresp=1.
- Read addr2 immediately after the B commit -> first rvalid no earlier than 32 cycles later (16 with AXI4_MUL_RADIX4_EN), then product 537321351*24627837 checked against a model.
- Write burst of 3 beats to addr0, or a write to addr3 -> bresp=0; readback of addr0 is unchanged; no restart (status done stays 1).
- awvalid and arvalid asserted together in IDLE -> write is accepted first, the read follows after bready; rready held low 5 cycles mid-burst -> rdata stable.
- Assert _rst during WDATA beat 2 and mid-multiply -> all outputs 0 the same cycle; status read afterwards = 0x00.
- Randomized bready/rready backpressure over 12 random operand pairs -> all products match; no protocol handshake violations.
